match_run_tracker: RTL

- Downstream consumer of the one-hot sequence detector's z output.
- Tracks each contiguous run of z=1 cycles ("match run"). Reports:
  - the current run length;
  - the length of the last completed run;
  - the longest run seen;
  - a saturating count of runs;
  - a one-cycle run-end strobe;
  - a sticky threshold alarm.
- Samples z directly on clk, in the same clock domain as the detector.

---
 rtl/match_run_tracker.sv | 94 +++++++++
 1 files changed

// File: rtl/match_run_tracker.sv
// Tracks contiguous runs of z=1 from the sequence detector: current/last/longest
// run length, saturating run count, one-cycle run-end strobe and sticky alarm.
module match_run_tracker #(
    parameter int CNT_W = 8,
    parameter int EVT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             z,
    input  logic             clear,
    input  logic [CNT_W-1:0] threshold,
    output logic [CNT_W-1:0] run_len,
    output logic [CNT_W-1:0] last_run,
    output logic [CNT_W-1:0] max_run,
    output logic [EVT_W-1:0] event_count,
    output logic             run_done,
    output logic             alarm
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [EVT_W-1:0] EVT_MAX = '1;

    state_t           state;
    logic [CNT_W-1:0] run_nxt;
    logic [EVT_W-1:0] evt_inc;

    // Next run length is shared by the run_len register and the alarm compare,
    // so the alarm fires on the same edge run_len reaches the threshold.
    always_comb begin
        run_nxt = '0;
        case (state)
            IDLE, DONE: run_nxt = z ? CNT_W'(1) : '0;
            RUN:        run_nxt = !z ? '0 :
                                  (run_len == CNT_MAX) ? run_len : run_len + CNT_W'(1);
            default:    run_nxt = '0;
        endcase
    end

    assign evt_inc = (event_count == EVT_MAX) ? event_count : event_count + EVT_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            run_len     <= '0;
            last_run    <= '0;
            max_run     <= '0;
            event_count <= '0;
            run_done    <= 1'b0;
            alarm       <= 1'b0;
        end else if (clear) begin
            state       <= IDLE;
            run_len     <= '0;
            last_run    <= '0;
            max_run     <= '0;
            event_count <= '0;
            run_done    <= 1'b0;
            alarm       <= 1'b0;
        end else begin
            run_len  <= run_nxt;
            run_done <= 1'b0;
            if (threshold != '0 && run_nxt >= threshold)
                alarm <= 1'b1;
            case (state)
                IDLE: begin
                    if (z) begin
                        state       <= RUN;
                        event_count <= evt_inc;
                    end
                end
                RUN: begin
                    if (!z) begin
                        state    <= DONE;
                        run_done <= 1'b1;
                        last_run <= run_len;
                        if (run_len > max_run)
                            max_run <= run_len;
                    end
                end
                DONE: begin
                    if (z) begin
                        state       <= RUN;
                        event_count <= evt_inc;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
